// File: rtl/dmem_cache.sv
// Direct-mapped, one-word-per-line data cache in front of a processor data-memory port.
// Reads allocate on miss; writes go through to memory and update only lines that already hit.
module dmem_cache #(
  parameter int unsigned LINES = 8,
  parameter int unsigned AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CEN,
  input  logic          WEN,
  input  logic          OEN,
  input  logic [AW-1:0] A,
  input  logic [31:0]   D,
  output logic [31:0]   Q,
  output logic          stall,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = AW - IW;

  typedef enum logic [1:0] {StIdle, StRfill, StWthru} state_e;

  state_e           state_q;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      data_q [LINES];
  logic             sup_q;

  logic [IW-1:0] idx, fill_idx;
  logic [TW-1:0] tag, fill_tag;
  logic          req, hit, held, rd_hit, rd_miss, wr_acc;

  assign idx      = A[IW-1:0];
  assign tag      = A[AW-1:IW];
  assign fill_idx = mem_addr[IW-1:0];
  assign fill_tag = mem_addr[AW-1:IW];

  always_comb begin
    req     = !rst && !CEN && (state_q == StIdle);
    hit     = req && valid_q[idx] && (tag_q[idx] == tag);
    // Same write still presented after its write-through finished: swallow it.
    held    = sup_q && !WEN && (A == mem_addr);
    rd_hit  = req && WEN && hit;
    rd_miss = req && WEN && !hit;
    wr_acc  = req && !WEN && !held;
    stall   = !rst && ((state_q != StIdle) || rd_miss || wr_acc);
    Q       = (rd_hit && !OEN) ? data_q[idx] : 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      valid_q   <= '0;
      sup_q     <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          sup_q <= !CEN && held;
          if (rd_miss) begin
            mem_addr <= A;
            mem_read <= 1'b1;
            state_q  <= StRfill;
          end else if (wr_acc) begin
            mem_addr  <= A;
            mem_wdata <= D;
            mem_write <= 1'b1;
            state_q   <= StWthru;
          end
        end
        StRfill: begin
          if (mem_ready) begin
            mem_read          <= 1'b0;
            valid_q[fill_idx] <= 1'b1;
            state_q           <= StIdle;
          end
        end
        StWthru: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
            sup_q     <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid_q alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == StRfill) && mem_ready) begin
      data_q[fill_idx] <= mem_rdata;
      tag_q[fill_idx]  <= fill_tag;
    end else if (wr_acc && hit) begin
      data_q[idx] <= D;
    end
  end

endmodule

// File: doc/dmem_cache.md
DMEM_CACHE -- requirements
Module: dmem_cache

Interface
REQ-001 SHALL have parameter LINES, default 8, meaning number of direct-mapped one-word cache lines (power of 2, 2..64).
REQ-002 SHALL have parameter AW, default 7, meaning word-address width, matching the processor data-memory port.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 CEN  input  1  chip enable, active low; request present when 0.
REQ-007 WEN  input  1  0 = write, 1 = read; qualified by CEN=0.
REQ-008 OEN  input  1  output enable, active low; gates Q.
REQ-009 A  input  AW  word address of the request.
REQ-010 D  input  32  write data.
REQ-011 Q  output  32  read data to the processor.
REQ-012 stall  output  1  1 = request not complete; processor holds CEN/WEN/A/D.
REQ-013 mem_read  output  1  backing-memory read strobe.
REQ-014 mem_write  output  1  backing-memory write strobe.
REQ-015 mem_addr  output  AW  backing-memory word address.
REQ-016 mem_wdata  output  32  backing-memory write data.
REQ-017 mem_rdata  input  32  backing-memory read data, valid when mem_ready=1.
REQ-018 mem_ready  input  1  backing memory completes the current strobe this cycle.

Function
REQ-019 Index = A[log2(LINES)-1:0]; tag = remaining upper bits of A; each line holds valid, tag, 32-bit data.
REQ-020 FSM states: IDLE, RFILL, WTHRU; only IDLE accepts new requests.
REQ-021 Hit = CEN=0, state IDLE, line valid, stored tag equals A tag.
REQ-022 Read hit (WEN=1): Q = line data combinationally same cycle; stall=0; no memory access; state stays IDLE.
REQ-023 Read miss in IDLE: stall=1 same cycle; A latched into mem_addr at the clock edge; next state RFILL.
REQ-024 RFILL: mem_read=1 and stall=1 every cycle until mem_ready=1; on that edge line[index] receives data=mem_rdata, tag, valid=1; next state IDLE.
REQ-025 After a fill, the held request hits in IDLE the next cycle; read-miss latency = memory wait cycles + 2.
REQ-026 Write (WEN=0) in IDLE: stall=1 same cycle; A and D latched into mem_addr and mem_wdata; next state WTHRU.
REQ-027 Write policy: write-through, no-write-allocate; a write hit updates line data at acceptance; a write miss leaves the cache unchanged.
REQ-028 WTHRU: mem_write=1 and stall=1 until mem_ready=1; then next state IDLE with stall=0 for one cycle, so the held write is not re-issued.
REQ-029 The cycle after WTHRU completes SHALL NOT accept the held write again; accept-suppression flag cleared when CEN=1 or A/WEN change.
REQ-030 mem_read and mem_write SHALL never both be 1; mem_addr and mem_wdata stay stable while a strobe is asserted.
REQ-031 mem_ready SHALL be ignored in IDLE.
REQ-032 Q = 0 when OEN=1, CEN=1, WEN=0, or on a read miss; never X.
REQ-033 CEN=1 in IDLE: stall=0, no state change.

Reset
REQ-034 rst=1 SHALL immediately force: state IDLE, all valid bits 0, stall=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, Q=0, suppression flag 0.
REQ-035 Reset mid-RFILL or mid-WTHRU SHALL abort the transfer with no line update; data arrays need no reset.

Verification
REQ-036 After reset, read A=0x05: stall=1, mem_read=1 with mem_addr=0x05; mem_ready after 3 cycles with rdata=0xDEADBEEF -> next cycle Q=0xDEADBEEF, stall=0.
REQ-037 Read A=0x05 again -> Q=0xDEADBEEF same cycle, stall=0, mem_read stays 0.
REQ-038 Write A=0x05 D=0x12345678 -> mem_write=1, mem_wdata=0x12345678 until mem_ready; one write only; later read 0x05 hits with 0x12345678.
REQ-039 Read A=0x0D (same index, different tag) -> miss, fill replaces line; read 0x05 then misses.
REQ-040 Write miss A=0x20 -> one memory write; read 0x20 then misses, so no allocation.
REQ-041 rst during RFILL with mem_ready pending -> mem_read drops immediately; read of the same address afterward misses.
